tap_and_uul_top: RTL and testbench

TAP_AND_UUL_TOP -- requirements
Module: tap_and_uul

---
 rtl/tap_and_uul_pkg.sv | 13 +
 rtl/tap_fsm.sv | 36 +++
 rtl/tap_and_uul_top.sv | 53 +++++
 tb/tb_tap_and_uul_top.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/tap_and_uul_pkg.sv
// tap_and_uul_pkg: TAP states, instruction opcodes and register lengths shared by the TAP and UUL
package tap_and_uul_pkg;
  localparam int IR_LEN = 3;
  localparam int BSR_LEN = 10;
  localparam logic [IR_LEN-1:0] OP_EXTEST = 3'b000;
  localparam logic [IR_LEN-1:0] OP_SAMPLE = 3'b010;
  localparam logic [IR_LEN-1:0] OP_BYPASS = 3'b111;
  typedef enum logic [3:0] {
    TLR, RTI,
    SEL_DR, CAP_DR, SHIFT_DR, EXIT1_DR, PAUSE_DR, EXIT2_DR, UPD_DR,
    SEL_IR, CAP_IR, SHIFT_IR, EXIT1_IR, PAUSE_IR, EXIT2_IR, UPD_IR
  } tap_state_e;
endpackage

// File: rtl/tap_fsm.sv
// tap_fsm: 16-state IEEE 1149.1 TAP controller stepping on TCK rising edges
module tap_fsm
  import tap_and_uul_pkg::*;
(
  input  logic       TCK,
  input  logic       TRST_n,
  input  logic       TMS,
  output tap_state_e state
);
  tap_state_e nxt;
  always_ff @(posedge TCK or negedge TRST_n)
    if (!TRST_n) state <= TLR;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      TLR:      nxt = TMS ? TLR      : RTI;
      RTI:      nxt = TMS ? SEL_DR   : RTI;
      SEL_DR:   nxt = TMS ? SEL_IR   : CAP_DR;
      CAP_DR:   nxt = TMS ? EXIT1_DR : SHIFT_DR;
      SHIFT_DR: nxt = TMS ? EXIT1_DR : SHIFT_DR;
      EXIT1_DR: nxt = TMS ? UPD_DR   : PAUSE_DR;
      PAUSE_DR: nxt = TMS ? EXIT2_DR : PAUSE_DR;
      EXIT2_DR: nxt = TMS ? UPD_DR   : SHIFT_DR;
      UPD_DR:   nxt = TMS ? SEL_DR   : RTI;
      SEL_IR:   nxt = TMS ? TLR      : CAP_IR;
      CAP_IR:   nxt = TMS ? EXIT1_IR : SHIFT_IR;
      SHIFT_IR: nxt = TMS ? EXIT1_IR : SHIFT_IR;
      EXIT1_IR: nxt = TMS ? UPD_IR   : PAUSE_IR;
      PAUSE_IR: nxt = TMS ? EXIT2_IR : PAUSE_IR;
      EXIT2_IR: nxt = TMS ? UPD_IR   : SHIFT_IR;
      UPD_IR:   nxt = TMS ? SEL_DR   : RTI;
      default:  nxt = TLR;
    endcase
  end
endmodule

// File: rtl/tap_and_uul_top.sv
// tap_and_uul_top: JTAG TAP with IR, bypass and boundary-scan register wrapped around a 3+3 bit adder
module tap_and_uul_top
  import tap_and_uul_pkg::*;
(
  input  logic       TCK,
  input  logic       TRST_n,
  input  logic       TMS,
  input  logic       TDI,
  output logic       TDO,
  output logic       TDI2,
  output logic       TCK2,
  output logic       TMS2,
  output logic       TDO2,
  input  logic [5:0] Par_in,
  output logic [3:0] Par_out,
  input  logic       clk_50MHz
);
  tap_state_e         state;
  logic [IR_LEN-1:0]  ir, ir_sr;
  logic [BSR_LEN-1:0] bsr, upd;
  logic               bypass, extest, sel_bsr, unused_clk;
  logic [3:0]         core_out;
  tap_fsm u_fsm (.TCK(TCK), .TRST_n(TRST_n), .TMS(TMS), .state(state));
  assign unused_clk = clk_50MHz;
  assign core_out = {1'b0, Par_in[2:0]} + {1'b0, Par_in[5:3]};
  assign extest = ir == OP_EXTEST;
  assign sel_bsr = extest || ir == OP_SAMPLE;
  assign Par_out = extest ? upd[9:6] : core_out;
  assign {TDI2, TCK2, TMS2, TDO2} = {TDI, TCK, TMS, TDO};
  // IR falls back to BYPASS on the same edge that enters Test-Logic-Reset
  always_ff @(posedge TCK or negedge TRST_n)
    if (!TRST_n) begin
      ir <= OP_BYPASS;
      ir_sr <= '0;
      bsr <= '0;
      upd <= '0;
      bypass <= 1'b0;
    end else begin
      if (state == TLR || (state == SEL_IR && TMS)) ir <= OP_BYPASS;
      else if (state == UPD_IR) ir <= ir_sr;
      if (state == CAP_IR) ir_sr <= 3'b001;
      else if (state == SHIFT_IR) ir_sr <= {TDI, ir_sr[IR_LEN-1:1]};
      if (sel_bsr) begin
        if (state == CAP_DR) bsr <= {core_out, Par_in};
        else if (state == SHIFT_DR) bsr <= {TDI, bsr[BSR_LEN-1:1]};
        if (state == UPD_DR) upd <= bsr;
      end else if (state == CAP_DR) bypass <= 1'b0;
      else if (state == SHIFT_DR) bypass <= TDI;
    end
  always_ff @(negedge TCK or negedge TRST_n)
    if (!TRST_n) TDO <= 1'b0;
    else TDO <= state == SHIFT_IR ? ir_sr[0] : state == SHIFT_DR ? (sel_bsr ? bsr[0] : bypass) : 1'b0;
endmodule

// File: tb/tb_tap_and_uul_top.sv
// tb_tap_and_uul_top: random JTAG operations against a register-level model, checked through a stamped scoreboard
module tb_tap_and_uul_top;
  logic       TCK = 0, TRST_n = 0, TMS = 1, TDI = 0, clk_50MHz = 0;
  logic [5:0] Par_in = 6'b011_010;
  logic       TDO, TDI2, TCK2, TMS2, TDO2;
  logic [3:0] Par_out;

  tap_and_uul_top dut (
    .TCK(TCK), .TRST_n(TRST_n), .TMS(TMS), .TDI(TDI), .TDO(TDO),
    .TDI2(TDI2), .TCK2(TCK2), .TMS2(TMS2), .TDO2(TDO2),
    .Par_in(Par_in), .Par_out(Par_out), .clk_50MHz(clk_50MHz)
  );

  always #5 TCK = ~TCK;
  always #10 clk_50MHz = ~clk_50MHz;

  typedef struct {
    int         stamp;
    bit         is_tdo;
    logic [3:0] exp;
    string      name;
  } item_t;

  item_t      sb[$];
  item_t      it;
  int         nedge = 0, vectors = 0, miscompares = 0;
  logic [2:0] m_ir = 3'b111;
  logic [9:0] m_upd = '0;

  function automatic logic [3:0] m_sum(input logic [5:0] p);
    return 4'(p[2:0]) + 4'(p[5:3]);
  endfunction

  function automatic logic [3:0] m_par();
    return m_ir == 3'b000 ? m_upd[9:6] : m_sum(Par_in);
  endfunction

  // expectation for the falling edge following the current one
  function automatic void push(input bit t, input logic [3:0] e, input string n);
    sb.push_back('{nedge + 1, t, e, n});
  endfunction

  initial forever begin
    @(negedge TCK);
    nedge++;
    #1;
    while (sb.size() > 0 && sb[0].stamp <= nedge) begin
      it = sb.pop_front();
      vectors++;
      if (it.is_tdo) begin
        if (TDO !== it.exp[0] || TDO2 !== it.exp[0] || TDI2 !== TDI || TMS2 !== TMS || TCK2 !== TCK) begin
          miscompares++;
          $display("FAIL %s @edge %0d: TDO=%b TDO2=%b TDI2/TMS2/TCK2=%b%b%b, expected TDO=%b TDI2/TMS2/TCK2=%b%b%b",
                   it.name, nedge, TDO, TDO2, TDI2, TMS2, TCK2, it.exp[0], TDI, TMS, TCK);
        end
      end else if (Par_out !== it.exp) begin
        miscompares++;
        $display("FAIL %s @edge %0d: Par_out=%b expected %b", it.name, nedge, Par_out, it.exp);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic step(input logic tms, input logic tdi);
    @(negedge TCK);
    #2;
    TMS = tms;
    TDI = tdi;
    @(posedge TCK);
  endtask

  // Starts and ends in Run-Test/Idle; a scanned register of length len emits cap then din
  task automatic scan(input bit ir_path, input int n, input logic [9:0] din, input logic [9:0] cap,
                      input int len, output logic [9:0] res);
    logic [19:0] stream;
    for (int j = 0; j < 20; j++) stream[j] = j < len ? cap[j] : (j - len < 10 ? din[j - len] : 1'b0);
    step(1, 0);
    if (ir_path) step(1, 0);
    step(0, 0);
    step(0, 0);
    push(1, {3'b0, stream[0]}, ir_path ? "ir_capture" : "dr_capture");
    for (int i = 0; i < n; i++) begin
      step(i == n - 1, din[i]);
      push(1, i == n - 1 ? 4'd0 : {3'b0, stream[i + 1]}, ir_path ? "ir_shift" : "dr_shift");
    end
    step(1, 0);
    step(0, 0);
    res = '0;
    for (int k = 0; k < len; k++) res[k] = din[n - len + k];
  endtask

  task automatic load_ir(input logic [2:0] op);
    logic [9:0] r;
    scan(1, 3, {7'b0, op}, 10'b001, 3, r);
    m_ir = r[2:0];
    push(0, m_par(), "par_after_ir");
  endtask

  task automatic scan_dr(input logic [9:0] din, input int n);
    logic [9:0] r;
    if (m_ir == 3'b000 || m_ir == 3'b010) begin
      scan(0, 10, din, {m_sum(Par_in), Par_in}, 10, r);
      m_upd = r;
    end else scan(0, n, din, 10'b0, 1, r);
    push(0, m_par(), "par_after_dr");
  endtask

  task automatic set_par(input logic [5:0] v);
    @(negedge TCK);
    #2;
    Par_in = v;
    push(0, m_par(), "par_out");
  endtask

  task automatic tms_reset();
    for (int i = 0; i < 5; i++) step(1, 1'($urandom));
    m_ir = 3'b111;
    push(0, m_par(), "tlr_par");
    push(1, 4'd0, "tlr_tdo");
    step(0, 0);
  endtask

  task automatic trst_pulse(input bit mid);
    if (mid) begin
      step(1, 0);
      step(0, 0);
      step(0, 0);
      step(0, 1);
      step(0, 0);
    end
    @(negedge TCK);
    #2;
    TRST_n = 0;
    m_ir = 3'b111;
    m_upd = '0;
    push(1, 4'd0, "trst_tdo");
    push(0, m_par(), "trst_par");
    @(negedge TCK);
    @(negedge TCK);
    #2;
    TRST_n = 1;
    step(0, 0);
  endtask

  initial begin
    @(negedge TCK);
    #2;
    push(1, 4'd0, "reset_tdo");
    push(0, 4'd5, "reset_par");
    @(negedge TCK);
    @(negedge TCK);
    #2;
    TRST_n = 1;
    step(0, 0);
    load_ir(3'b010);
    set_par(6'b000_111);
    scan_dr(10'($urandom), 10);
    scan_dr(10'b1010_000000, 10);
    load_ir(3'b000);
    set_par(6'b110_101);
    tms_reset();
    load_ir(3'b111);
    scan_dr(10'b1101, 4);
    load_ir(3'b000);
    set_par(6'($urandom));
    trst_pulse(1);
    load_ir(3'b000);
    for (int n = 0; n < 80; n++) begin
      case ($urandom_range(0, 5))
        0: set_par(6'($urandom));
        1: load_ir(3'($urandom));
        2: load_ir($urandom_range(0, 1) ? 3'b000 : 3'b010);
        3: scan_dr(10'($urandom), $urandom_range(4, 8));
        4: tms_reset();
        default: trst_pulse(1'($urandom));
      endcase
    end
    repeat (4) @(negedge TCK);
    #2;
    if (sb.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL scoreboard_drain: %0d expectations left unchecked, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
